fifo_wr_arbiter: RTL

Write-side controller for the async TX FIFO: shares the FIFO's single write port between the register-file read path (1 byte per response) and the ALU result path (2 bytes per response). It runs in the FIFO write clock domain, arbitrates round-robin, serialises the ALU result LSB-first, and stalls on `Full` without losing or duplicating bytes. Its outputs drive the FIFO's `W_INC` and `WR_DATA` directly; its `Full` input comes straight from the FIFO.

---
 rtl/fifo_wr_arbiter.sv | 57 +++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin RF/ALU arbiter serialising responses into the TX FIFO write port
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RF_VLD,
  input  logic [DATA_WIDTH-1:0]     RF_DATA,
  output logic                      RF_RDY,
  input  logic                      ALU_VLD,
  input  logic [2*DATA_WIDTH-1:0]   ALU_DATA,
  output logic                      ALU_RDY,
  input  logic                      FULL,
  output logic                      W_INC,
  output logic [DATA_WIDTH-1:0]     WR_DATA,
  output logic                      BUSY
);
  typedef enum logic [1:0] {IDLE, WR_RF, WR_ALU_LO, WR_ALU_HI} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] hold_rf;
  logic [2*DATA_WIDTH-1:0] hold_alu;
  logic last_grant, grant_rf, grant_alu;
  assign grant_rf = RF_VLD && (!ALU_VLD || last_grant);
  assign grant_alu = ALU_VLD && (!RF_VLD || !last_grant);
  // Strobes and writes are masked while RST is high so a half-written ALU pair is never completed
  always_comb begin
    RF_RDY = state == IDLE && !RST && grant_rf;
    ALU_RDY = state == IDLE && !RST && grant_alu;
    W_INC = state != IDLE && !RST && !FULL;
    BUSY = state != IDLE;
    WR_DATA = state == WR_RF     ? hold_rf :
              state == WR_ALU_LO ? hold_alu[DATA_WIDTH-1:0] :
              state == WR_ALU_HI ? hold_alu[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    state_nx = RF_RDY  ? WR_RF :
               ALU_RDY ? WR_ALU_LO :
               !W_INC  ? state :
               state == WR_ALU_LO ? WR_ALU_HI : IDLE;
  end
  // State, captured data and round-robin pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      hold_rf <= '0;
      hold_alu <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      if (RF_RDY) begin
        hold_rf <= RF_DATA;
        last_grant <= 1'b0;
      end else if (ALU_RDY) begin
        hold_alu <= ALU_DATA;
        last_grant <= 1'b1;
      end
    end
  end
endmodule
